// File: rtl/abr_prim_subreg_ext_fifo.sv
// abr_prim_subreg_ext_fifo
// Hardware-side endpoint for an external (hwext) CSR subregister. Software
// writes (qe/q) are pushed into a write FIFO that drains to a hardware
// consumer. Software reads (qre) pop a read FIFO that a hardware producer
// fills. Read data d is combinational, so the register block samples the
// entry being popped in the same cycle as qre.
//
// Ports:
//   clk, rst_b              clock, synchronous active-low reset
//   qe, q                   register write strobe and data
//   qre, d                  register read strobe and read data
//   wr_valid/wr_data/wr_ready  write FIFO head towards HW consumer
//   rd_valid/rd_data/rd_ready  HW producer into the read FIFO
//   wr_cnt, rd_cnt          FIFO occupancies
//   wr_overflow             sticky: write dropped because write FIFO full
//   rd_underflow            sticky: read while read FIFO empty
//   err_clr                 clears both sticky flags
module abr_prim_subreg_ext_fifo #(
    parameter int DW       = 32,
    parameter int WR_DEPTH = 4,
    parameter int RD_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            qe,
    input  logic [DW-1:0]                   q,
    input  logic                            qre,
    output logic [DW-1:0]                   d,
    output logic                            wr_valid,
    output logic [DW-1:0]                   wr_data,
    input  logic                            wr_ready,
    input  logic                            rd_valid,
    input  logic [DW-1:0]                   rd_data,
    output logic                            rd_ready,
    output logic [$clog2(WR_DEPTH+1)-1:0]   wr_cnt,
    output logic [$clog2(RD_DEPTH+1)-1:0]   rd_cnt,
    output logic                            wr_overflow,
    output logic                            rd_underflow,
    input  logic                            err_clr
);

    localparam int WCW = $clog2(WR_DEPTH + 1);
    localparam int WPW = $clog2(WR_DEPTH);
    localparam int RCW = $clog2(RD_DEPTH + 1);
    localparam int RPW = $clog2(RD_DEPTH);

    localparam logic [WCW-1:0] WR_FULL = WCW'(WR_DEPTH);
    localparam logic [WPW-1:0] WR_LAST = WPW'(WR_DEPTH - 1);
    localparam logic [RCW-1:0] RD_FULL = RCW'(RD_DEPTH);
    localparam logic [RPW-1:0] RD_LAST = RPW'(RD_DEPTH - 1);

    // ---------------------------------------------------------------
    // Write FIFO (software -> hardware)
    // ---------------------------------------------------------------
    logic [DW-1:0]  wr_mem [WR_DEPTH];
    logic [WPW-1:0] wr_head;
    logic [WPW-1:0] wr_tail;
    logic           wr_push;
    logic           wr_pop;

    assign wr_valid = (wr_cnt != '0);
    assign wr_data  = wr_mem[wr_head];
    assign wr_pop   = wr_valid & wr_ready;
    // A full FIFO still takes the write when the consumer frees a slot
    // in the same cycle.
    assign wr_push  = qe & ((wr_cnt != WR_FULL) | wr_pop);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_head <= '0;
            wr_tail <= '0;
            wr_cnt  <= '0;
        end else begin
            if (wr_push) begin
                wr_tail <= (wr_tail == WR_LAST) ? '0 : wr_tail + WPW'(1);
            end
            if (wr_pop) begin
                wr_head <= (wr_head == WR_LAST) ? '0 : wr_head + WPW'(1);
            end
            case ({wr_push, wr_pop})
                2'b10:   wr_cnt <= wr_cnt + WCW'(1);
                2'b01:   wr_cnt <= wr_cnt - WCW'(1);
                default: wr_cnt <= wr_cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wr_mem[wr_tail] <= q;
        end
    end

    // ---------------------------------------------------------------
    // Read FIFO (hardware -> software)
    // ---------------------------------------------------------------
    logic [DW-1:0]  rd_mem [RD_DEPTH];
    logic [RPW-1:0] rd_head;
    logic [RPW-1:0] rd_tail;
    logic           rd_push;
    logic           rd_pop;
    logic           rd_empty;

    assign rd_empty = (rd_cnt == '0);
    // Not-full only; a same-cycle pop does not open the door for a push.
    assign rd_ready = (rd_cnt != RD_FULL);
    assign rd_push  = rd_valid & rd_ready;
    assign rd_pop   = qre & ~rd_empty;
    assign d        = rd_empty ? '0 : rd_mem[rd_head];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rd_head <= '0;
            rd_tail <= '0;
            rd_cnt  <= '0;
        end else begin
            if (rd_push) begin
                rd_tail <= (rd_tail == RD_LAST) ? '0 : rd_tail + RPW'(1);
            end
            if (rd_pop) begin
                rd_head <= (rd_head == RD_LAST) ? '0 : rd_head + RPW'(1);
            end
            case ({rd_push, rd_pop})
                2'b10:   rd_cnt <= rd_cnt + RCW'(1);
                2'b01:   rd_cnt <= rd_cnt - RCW'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_mem[rd_tail] <= rd_data;
        end
    end

    // ---------------------------------------------------------------
    // Sticky error flags; a new event beats a same-cycle clear.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            if (qe & ~wr_push) begin
                wr_overflow <= 1'b1;
            end else if (err_clr) begin
                wr_overflow <= 1'b0;
            end
            if (qre & rd_empty) begin
                rd_underflow <= 1'b1;
            end else if (err_clr) begin
                rd_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_abr_prim_subreg_ext_fifo.sv
// Testbench for abr_prim_subreg_ext_fifo: table-driven vectors plus a
// queue-based scoreboard checked every cycle, and hand-written sequences
// for full/concurrent read FIFO handling and mid-traffic reset.
module tb_abr_prim_subreg_ext_fifo;

    localparam int DW = 32;
    localparam int WR_DEPTH = 4;
    localparam int RD_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          qe;
    logic [DW-1:0] q;
    logic          qre;
    logic [DW-1:0] d;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [2:0]    wr_cnt;
    logic [2:0]    rd_cnt;
    logic          wr_overflow;
    logic          rd_underflow;
    logic          err_clr;

    always #5 clk = ~clk;

    abr_prim_subreg_ext_fifo #(
        .DW(DW), .WR_DEPTH(WR_DEPTH), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .clk(clk), .rst_b(rst_b), .qe(qe), .q(q), .qre(qre), .d(d),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
        .wr_overflow(wr_overflow), .rd_underflow(rd_underflow),
        .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard state
    logic [DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic          qe;
        logic [DW-1:0] q;
        logic          qre;
        logic          wr_ready;
        logic          rd_valid;
        logic [DW-1:0] rd_data;
        logic          err_clr;
        int            exp_wc;
        int            exp_rc;
        logic          exp_ovf;
        logic          exp_unf;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] exp_wrd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic i_qe, input logic [DW-1:0] i_q, input logic i_qre,
                                input logic i_wrdy, input logic i_rdv, input logic [DW-1:0] i_rdd,
                                input logic i_clr, input int e_wc, input int e_rc,
                                input logic e_ovf, input logic e_unf,
                                input logic [DW-1:0] e_d, input logic [DW-1:0] e_wrd);
        vec_t v;
        v.qe = i_qe; v.q = i_q; v.qre = i_qre; v.wr_ready = i_wrdy;
        v.rd_valid = i_rdv; v.rd_data = i_rdd; v.err_clr = i_clr;
        v.exp_wc = e_wc; v.exp_rc = e_rc; v.exp_ovf = e_ovf; v.exp_unf = e_unf;
        v.exp_d = e_d; v.exp_wrd = e_wrd;
        vecs.push_back(v);
    endfunction

    task automatic idle();
        qe = 0; q = '0; qre = 0; wr_ready = 0; rd_valid = 0; rd_data = '0; err_clr = 0;
    endtask

    // Called just after a negedge with inputs driven: checks current
    // outputs against the model, updates the model, and returns at the
    // following negedge.
    task automatic step();
        logic          rpush;
        logic          wovf_ev;
        logic          runf_ev;
        logic [DW-1:0] e;
        #1;
        if (rst_b) begin
            check("wr_valid", 32'(wr_valid), 32'(wq.size() > 0));
            check("rd_ready", 32'(rd_ready), 32'(rq.size() < RD_DEPTH));
            check("wr_cnt", 32'(wr_cnt), wq.size());
            check("rd_cnt", 32'(rd_cnt), rq.size());
            check("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
            check("rd_underflow", 32'(rd_underflow), 32'(m_unf));
            if (rq.size() == 0) check("d_empty", d, '0);
            // write side: HW pop first, then SW push into freed slot
            if (wr_ready && wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_data_pop", wr_data, e);
            end
            wovf_ev = qe && (wq.size() >= WR_DEPTH);
            if (qe && !wovf_ev) wq.push_back(q);
            // read side: push acceptance is decided on pre-pop occupancy
            rpush   = rd_valid && (rq.size() < RD_DEPTH);
            runf_ev = qre && (rq.size() == 0);
            if (qre && rq.size() > 0) begin
                e = rq.pop_front();
                check("d_pop", d, e);
            end
            if (rpush) rq.push_back(rd_data);
            m_ovf = wovf_ev ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            m_unf = runf_ev ? 1'b1 : (err_clr ? 1'b0 : m_unf);
        end else begin
            wq.delete();
            rq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_d", d, '0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd1);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst_wr_overflow", 32'(wr_overflow), 32'd0);
        check("rst_rd_underflow", 32'(rd_underflow), 32'd0);
    endtask

    initial begin
        // qe q qre wrdy rdv rdd clr | wc rc ovf unf d wrd
        // Write path
        add(1, 32'h11, 0, 0, 0, '0, 0,   1, 0, 0, 0, '0, 32'h11);
        add(1, 32'h22, 0, 0, 0, '0, 0,   2, 0, 0, 0, '0, 32'h11);
        add(1, 32'h33, 0, 0, 0, '0, 0,   3, 0, 0, 0, '0, 32'h11);
        add(0, '0,     0, 1, 0, '0, 0,   2, 0, 0, 0, '0, 32'h22);
        add(0, '0,     0, 1, 0, '0, 0,   1, 0, 0, 0, '0, 32'h33);
        add(0, '0,     0, 1, 0, '0, 0,   0, 0, 0, 0, '0, '0);
        // Write overflow, clear, full push with simultaneous pop
        add(1, 32'h41, 0, 0, 0, '0, 0,   1, 0, 0, 0, '0, 32'h41);
        add(1, 32'h42, 0, 0, 0, '0, 0,   2, 0, 0, 0, '0, 32'h41);
        add(1, 32'h43, 0, 0, 0, '0, 0,   3, 0, 0, 0, '0, 32'h41);
        add(1, 32'h44, 0, 0, 0, '0, 0,   4, 0, 0, 0, '0, 32'h41);
        add(1, 32'h55, 0, 0, 0, '0, 0,   4, 0, 1, 0, '0, 32'h41);
        add(0, '0,     0, 0, 0, '0, 1,   4, 0, 0, 0, '0, 32'h41);
        add(1, 32'h66, 0, 1, 0, '0, 0,   4, 0, 0, 0, '0, 32'h42);
        add(0, '0,     0, 1, 0, '0, 0,   3, 0, 0, 0, '0, 32'h43);
        add(0, '0,     0, 1, 0, '0, 0,   2, 0, 0, 0, '0, 32'h44);
        add(0, '0,     0, 1, 0, '0, 0,   1, 0, 0, 0, '0, 32'h66);
        add(0, '0,     0, 1, 0, '0, 0,   0, 0, 0, 0, '0, '0);
        // Read path
        add(0, '0, 0, 0, 1, 32'hA0, 0,   0, 1, 0, 0, 32'hA0, '0);
        add(0, '0, 0, 0, 1, 32'hA1, 0,   0, 2, 0, 0, 32'hA0, '0);
        add(0, '0, 1, 0, 0, '0,     0,   0, 1, 0, 0, 32'hA1, '0);
        add(0, '0, 1, 0, 0, '0,     0,   0, 0, 0, 0, '0, '0);
        // Read underflow and clear races
        add(0, '0, 1, 0, 0, '0,     0,   0, 0, 0, 1, '0, '0);
        add(0, '0, 0, 0, 0, '0,     1,   0, 0, 0, 0, '0, '0);
        add(0, '0, 1, 0, 0, '0,     1,   0, 0, 0, 1, '0, '0);
        add(0, '0, 0, 0, 0, '0,     1,   0, 0, 0, 0, '0, '0);
        // qe and qre together
        add(1, 32'h77, 0, 0, 1, 32'hB0, 0,   1, 1, 0, 0, 32'hB0, 32'h77);
        add(1, 32'h78, 1, 1, 0, '0,     0,   1, 0, 0, 0, '0, 32'h78);
        add(0, '0,     0, 1, 0, '0,     0,   0, 0, 0, 0, '0, '0);

        m_ovf = 0;
        m_unf = 0;
        idle();
        rst_b = 0;
        @(negedge clk);
        step();
        rst_b = 1;
        check_reset_state();

        foreach (vecs[i]) begin
            qe = vecs[i].qe; q = vecs[i].q; qre = vecs[i].qre;
            wr_ready = vecs[i].wr_ready; rd_valid = vecs[i].rd_valid;
            rd_data = vecs[i].rd_data; err_clr = vecs[i].err_clr;
            step();
            idle();
            check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), vecs[i].exp_wc);
            check($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt), vecs[i].exp_rc);
            check($sformatf("v%0d_ovf", i), 32'(wr_overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_unf", i), 32'(rd_underflow), 32'(vecs[i].exp_unf));
            check($sformatf("v%0d_d", i), d, vecs[i].exp_d);
            if (vecs[i].exp_wc > 0) check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_wrd);
        end

        // Fill read FIFO to full
        for (int k = 0; k < RD_DEPTH; k++) begin
            rd_valid = 1; rd_data = 32'hC0 + 32'(k);
            step();
        end
        idle();
        check("full_rd_ready", 32'(rd_ready), 32'd0);
        check("full_rd_cnt", 32'(rd_cnt), 32'd4);
        // Pop and offer at full: only the pop happens
        qre = 1; rd_valid = 1; rd_data = 32'hD0;
        step();
        idle();
        check("conc_rd_cnt", 32'(rd_cnt), 32'd3);
        check("conc_d", d, 32'hC1);
        rd_valid = 1; rd_data = 32'hD0;
        step();
        idle();
        check("conc_push_rd_cnt", 32'(rd_cnt), 32'd4);
        // Drain, scoreboard confirms order C1,C2,C3,D0
        for (int k = 0; k < RD_DEPTH; k++) begin
            qre = 1;
            step();
        end
        idle();
        check("drain_rd_cnt", 32'(rd_cnt), 32'd0);

        // Mid-traffic reset
        qe = 1; q = 32'hE1; rd_valid = 1; rd_data = 32'hF1;
        step();
        qe = 1; q = 32'hE2; rd_valid = 1; rd_data = 32'hF2;
        step();
        qe = 1; q = 32'hE3; rd_valid = 1; rd_data = 32'hF3; qre = 1;
        step();
        qre = 0; qe = 1; q = 32'hE4; rd_valid = 1; rd_data = 32'hF4; rst_b = 0;
        step();
        idle();
        rst_b = 1;
        check_reset_state();
        // Nothing survives: a fresh push shows on d and wr_data
        qe = 1; q = 32'h99; rd_valid = 1; rd_data = 32'h88;
        step();
        idle();
        check("post_rst_d", d, 32'h88);
        check("post_rst_wr_data", wr_data, 32'h99);
        check("post_rst_wr_cnt", 32'(wr_cnt), 32'd1);
        wr_ready = 1; qre = 1;
        step();
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
